press_event_queue: RTL and testbench

PRESS_EVENT_QUEUE -- requirements
Module: press_event_queue

---
 rtl/press_event_queue.sv | 111 +++++++++++
 tb/tb_press_event_queue.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/press_event_queue.sv
// Button press event queue: latches single-cycle press pulses into a pending
// register and serialises them, lowest button first, into a small FIFO.
module press_event_queue #(
    parameter int unsigned DEPTH_LOG2 = 3,
    parameter int unsigned DROP_W     = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [3:0]            btnPulse,
    input  logic                  eventReady,
    output logic                  eventValid,
    output logic [1:0]            eventCode,
    output logic [DEPTH_LOG2:0]   fifoCount,
    output logic [DROP_W-1:0]     dropCount
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned PTR_W = DEPTH_LOG2;
    localparam int unsigned CNT_W = DEPTH_LOG2 + 1;
    localparam int unsigned SUM_W = DROP_W + 3;

    logic [3:0]        r_pending;
    logic [1:0]        r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr;
    logic [PTR_W-1:0]  r_rd;
    logic [CNT_W-1:0]  r_count;
    logic [DROP_W-1:0] r_drop;
    logic              r_valid;
    logic [1:0]        r_code;

    logic              w_full;
    logic              w_pop;
    logic              w_push;
    logic [1:0]        w_sel_idx;
    logic [3:0]        w_push_mask;
    logic [3:0]        w_drop;
    logic [2:0]        w_drop_n;
    logic [SUM_W-1:0]  w_drop_sum;
    logic [DROP_W-1:0] w_drop_next;
    logic [PTR_W-1:0]  w_wr_next;
    logic [PTR_W-1:0]  w_rd_next;
    logic [CNT_W-1:0]  w_count_next;
    logic [1:0]        w_head_next;
    logic [3:0]        w_pending_next;

    // Fixed-priority select: button 0 wins.
    always_comb begin
        w_sel_idx = 2'd3;
        if (r_pending[0])      w_sel_idx = 2'd0;
        else if (r_pending[1]) w_sel_idx = 2'd1;
        else if (r_pending[2]) w_sel_idx = 2'd2;
    end

    // A full FIFO still accepts a push when the head leaves on the same edge.
    always_comb begin
        w_full       = (r_count == CNT_W'(DEPTH));
        w_pop        = r_valid & eventReady;
        w_push       = (|r_pending) & (~w_full | w_pop);
        w_push_mask  = w_push ? (4'b0001 << w_sel_idx) : 4'b0000;

        w_pending_next = (r_pending & ~w_push_mask) | btnPulse;

        w_drop      = btnPulse & r_pending & ~w_push_mask;
        w_drop_n    = 3'(w_drop[0]) + 3'(w_drop[1]) + 3'(w_drop[2]) + 3'(w_drop[3]);
        w_drop_sum  = SUM_W'(r_drop) + SUM_W'(w_drop_n);
        w_drop_next = (w_drop_sum > SUM_W'({DROP_W{1'b1}})) ? {DROP_W{1'b1}}
                                                            : w_drop_sum[DROP_W-1:0];

        w_wr_next = w_push ? r_wr + PTR_W'(1) : r_wr;
        w_rd_next = w_pop  ? r_rd + PTR_W'(1) : r_rd;

        w_count_next = r_count;
        if (w_push && !w_pop)      w_count_next = r_count + CNT_W'(1);
        else if (w_pop && !w_push) w_count_next = r_count - CNT_W'(1);

        // Bypass when the entry written this edge becomes the new head.
        w_head_next = (w_push && (r_wr == w_rd_next)) ? w_sel_idx : r_mem[w_rd_next];
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_pending <= 4'b0000;
            r_wr      <= '0;
            r_rd      <= '0;
            r_count   <= '0;
            r_drop    <= '0;
            r_valid   <= 1'b0;
            r_code    <= 2'd0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= 2'd0;
            end
        end else begin
            r_pending <= w_pending_next;
            r_wr      <= w_wr_next;
            r_rd      <= w_rd_next;
            r_count   <= w_count_next;
            r_drop    <= w_drop_next;
            r_valid   <= (w_count_next != '0);
            r_code    <= w_head_next;
            if (w_push) begin
                r_mem[r_wr] <= w_sel_idx;
            end
        end
    end

    assign eventValid = r_valid;
    assign eventCode  = r_code;
    assign fifoCount  = r_count;
    assign dropCount  = r_drop;

endmodule

// File: tb/tb_press_event_queue.sv
// Directed bench for press_event_queue: a vector table plus hand-built
// sequences for backpressure, pointer wrap, drop saturation and reset flush.
module tb_press_event_queue;

    logic       clock;
    logic       reset;
    logic [3:0] btnPulse;
    logic       eventReady;
    logic       eventValid;
    logic [1:0] eventCode;
    logic [3:0] fifoCount;
    logic [7:0] dropCount;
    logic       s_valid;
    logic [1:0] s_code;
    logic [3:0] s_count;
    logic [1:0] s_drop;

    int n_pass  = 0;
    int n_total = 0;

    press_event_queue dut (
        .clock(clock), .reset(reset), .btnPulse(btnPulse), .eventReady(eventReady),
        .eventValid(eventValid), .eventCode(eventCode), .fifoCount(fifoCount),
        .dropCount(dropCount)
    );

    press_event_queue #(.DEPTH_LOG2(3), .DROP_W(2)) dut_sat (
        .clock(clock), .reset(reset), .btnPulse(btnPulse), .eventReady(eventReady),
        .eventValid(s_valid), .eventCode(s_code), .fifoCount(s_count),
        .dropCount(s_drop)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] btn;
        logic       rdy;
        logic       exp_valid;
        logic [1:0] exp_code;
        logic [3:0] exp_cnt;
        logic [7:0] exp_drop;
        logic [1:0] exp_sat;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step(input logic [3:0] btn, input logic rdy);
        @(negedge clock);
        btnPulse   = btn;
        eventReady = rdy;
        @(posedge clock);
        #1;
    endtask

    task automatic check_state(input string tag, input logic v, input logic [1:0] c,
                               input logic [3:0] n, input logic [7:0] d);
        check({tag, ".valid"}, int'(eventValid), int'(v));
        if (v) check({tag, ".code"}, int'(eventCode), int'(c));
        check({tag, ".count"}, int'(fifoCount), int'(n));
        check({tag, ".drop"}, int'(dropCount), int'(d));
    endtask

    task automatic do_reset(input string tag);
        @(negedge clock);
        reset      = 1'b0;
        btnPulse   = 4'b1111;
        eventReady = 1'b1;
        @(posedge clock);
        #1;
        check_state(tag, 1'b0, 2'd0, 4'd0, 8'd0);
        check({tag, ".code"}, int'(eventCode), 0);
        check({tag, ".sat_drop"}, int'(s_drop), 0);
        @(negedge clock);
        reset    = 1'b1;
        btnPulse = 4'b0000;
    endtask

    initial begin
        reset      = 1'b0;
        btnPulse   = 4'b0000;
        eventReady = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_state("reset", 1'b0, 2'd0, 4'd0, 8'd0);
        check("reset.code", int'(eventCode), 0);
        @(negedge clock);
        reset = 1'b1;

        vecs[0]  = '{4'b0100, 1'b0, 1'b0, 2'd0, 4'd0, 8'd0, 2'd0};
        vecs[1]  = '{4'b0000, 1'b0, 1'b1, 2'd2, 4'd1, 8'd0, 2'd0};
        vecs[2]  = '{4'b0000, 1'b1, 1'b0, 2'd0, 4'd0, 8'd0, 2'd0};
        vecs[3]  = '{4'b1011, 1'b1, 1'b0, 2'd0, 4'd0, 8'd0, 2'd0};
        vecs[4]  = '{4'b0000, 1'b1, 1'b1, 2'd0, 4'd1, 8'd0, 2'd0};
        vecs[5]  = '{4'b0000, 1'b1, 1'b1, 2'd1, 4'd1, 8'd0, 2'd0};
        vecs[6]  = '{4'b0000, 1'b1, 1'b1, 2'd3, 4'd1, 8'd0, 2'd0};
        vecs[7]  = '{4'b0000, 1'b1, 1'b0, 2'd0, 4'd0, 8'd0, 2'd0};
        vecs[8]  = '{4'b0001, 1'b0, 1'b0, 2'd0, 4'd0, 8'd0, 2'd0};
        vecs[9]  = '{4'b0001, 1'b0, 1'b1, 2'd0, 4'd1, 8'd0, 2'd0};
        vecs[10] = '{4'b0011, 1'b0, 1'b1, 2'd0, 4'd2, 8'd0, 2'd0};
        vecs[11] = '{4'b0010, 1'b0, 1'b1, 2'd0, 4'd3, 8'd1, 2'd1};
        vecs[12] = '{4'b1111, 1'b0, 1'b1, 2'd0, 4'd4, 8'd1, 2'd1};
        vecs[13] = '{4'b1111, 1'b0, 1'b1, 2'd0, 4'd5, 8'd4, 2'd3};

        for (int i = 0; i < 14; i++) begin
            step(vecs[i].btn, vecs[i].rdy);
            check_state($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_code,
                        vecs[i].exp_cnt, vecs[i].exp_drop);
            check($sformatf("vec%0d.sat_drop", i), int'(s_drop), int'(vecs[i].exp_sat));
        end

        // Fill to full on button 1, then backpressure button 2.
        do_reset("rst_a");
        for (int i = 0; i < 8; i++) begin
            step(4'b0010, 1'b0);
            step(4'b0000, 1'b0);
        end
        check_state("full", 1'b1, 2'd1, 4'd8, 8'd0);
        step(4'b0100, 1'b0);
        check_state("full_hold", 1'b1, 2'd1, 4'd8, 8'd0);
        step(4'b0100, 1'b0);
        check_state("full_drop", 1'b1, 2'd1, 4'd8, 8'd1);
        step(4'b0000, 1'b1);
        check_state("full_poppush", 1'b1, 2'd1, 4'd8, 8'd1);
        for (int k = 0; k < 8; k++) begin
            step(4'b0000, 1'b1);
            check_state($sformatf("drain%0d", k), (k < 7), (k == 6) ? 2'd2 : 2'd1,
                        4'(7 - k), 8'd1);
        end

        // Twenty spaced presses walk the pointers around the ring twice.
        do_reset("rst_b");
        for (int i = 0; i < 20; i++) begin
            logic [3:0] oh;
            oh = 4'b0001 << (i % 4);
            step(oh, 1'b1);
            check($sformatf("wrap%0d.idle", i), int'(eventValid), 0);
            step(4'b0000, 1'b1);
            check_state($sformatf("wrap%0d", i), 1'b1, 2'(i % 4), 4'd1, 8'd0);
            step(4'b0000, 1'b1);
            check($sformatf("wrap%0d.gone", i), int'(fifoCount), 0);
        end

        // Drop saturation on the narrow counter.
        do_reset("rst_c");
        step(4'b1111, 1'b0);
        check("sat0", int'(s_drop), 0);
        step(4'b1111, 1'b0);
        check("sat1", int'(s_drop), 3);
        check("sat1.wide", int'(dropCount), 3);
        step(4'b1110, 1'b0);
        check("sat2", int'(s_drop), 3);
        check("sat2.wide", int'(dropCount), 6);
        step(4'b1111, 1'b0);
        check("sat3", int'(s_drop), 3);
        check("sat3.wide", int'(dropCount), 8);
        check("sat3.count", int'(fifoCount), 3);

        // Mid-operation reset, preceded by an unsampled reset glitch.
        do_reset("rst_d");
        step(4'b1110, 1'b0);
        step(4'b0010, 1'b0);
        step(4'b0010, 1'b0);
        step(4'b0100, 1'b0);
        step(4'b1000, 1'b0);
        @(negedge clock);
        btnPulse = 4'b0001;
        #1 reset = 1'b0;
        #1 reset = 1'b1;
        @(posedge clock);
        #1;
        check_state("pre_flush", 1'b1, 2'd1, 4'd5, 8'd2);
        do_reset("flush");
        for (int i = 0; i < 3; i++) begin
            step(4'b0000, 1'b1);
            check_state($sformatf("post_flush%0d", i), 1'b0, 2'd0, 4'd0, 8'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
